// File: rtl/tdc_tap_encoder.sv
// Thermometer tap encoder for a TDC delay line: double-samples the taps, detects a hit,
// encodes fine time plus coarse count, and hands it off on valid/ready followed by dead time.
// Optional macro TDC_BUBBLE_FILTER_EN: 3-tap majority bubble filter ahead of the popcount.
module tdc_tap_encoder #(
  parameter int NTAPS       = 32,
  parameter int FINE_W      = 6,
  parameter int COARSE_W    = 16,
  parameter int DEAD_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [NTAPS-1:0]    taps_in,
  output logic                ts_valid,
  input  logic                ts_ready,
  output logic [COARSE_W-1:0] ts_coarse,
  output logic [FINE_W-1:0]   ts_fine,
  output logic                ts_sat,
  output logic                coarse_wrap,
  output logic [7:0]          missed_cnt,
  output logic                busy
);

  localparam int DCW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    DEAD = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [NTAPS-1:0]    r_s1;
  logic [NTAPS-1:0]    r_s2;
  logic                r_s2q0;
  logic [COARSE_W-1:0] r_coarse;
  logic [COARSE_W-1:0] r_c1;
  logic [COARSE_W-1:0] r_c2;
  logic                r_wrap;
  logic [COARSE_W-1:0] r_ts_coarse;
  logic [FINE_W-1:0]   r_ts_fine;
  logic                r_ts_sat;
  logic [DCW-1:0]      r_dead;
  logic [7:0]          r_missed;
  logic [NTAPS-1:0]    w_filt;
  logic [FINE_W-1:0]   w_fine;
  logic                w_sat;
  logic                w_hit;
  logic                w_capture;
  logic                w_accept;

  // Sampling pipeline; the coarse count rides alongside the taps so both refer to one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_s2q0   <= 1'b0;
      r_c1     <= '0;
      r_c2     <= '0;
      r_coarse <= '0;
      r_wrap   <= 1'b0;
    end else begin
      r_s1     <= taps_in;
      r_s2     <= r_s1;
      r_s2q0   <= r_s2[0];
      r_c1     <= r_coarse;
      r_c2     <= r_c1;
      r_coarse <= r_coarse + 1'b1;
      r_wrap   <= (r_coarse == '1);
    end
  end

  assign w_hit = r_s2[0] & ~r_s2q0;
  assign w_sat = &r_s2;

`ifdef TDC_BUBBLE_FILTER_EN
  // Virtual neighbours: below tap 0 reads 1, above the last tap reads 0.
  logic [NTAPS+1:0] w_ext;
  assign w_ext = {1'b0, r_s2, 1'b1};
  for (genvar gi = 0; gi < NTAPS; gi++) begin : g_maj
    assign w_filt[gi] = (w_ext[gi] & w_ext[gi+1]) |
                        (w_ext[gi+1] & w_ext[gi+2]) |
                        (w_ext[gi] & w_ext[gi+2]);
  end
`else
  assign w_filt = r_s2;
`endif

  always_comb begin
    w_fine = '0;
    for (int unsigned i = 0; i < NTAPS; i++) begin
      w_fine = w_fine + FINE_W'(w_filt[i]);
    end
  end

  assign w_capture = (r_state == IDLE) & w_hit & enable;
  assign w_accept  = (r_state == HOLD) & ts_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_capture) w_next = HOLD;
      HOLD:    if (w_accept) w_next = DEAD;
      DEAD:    if (r_dead == '0) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ts_coarse <= '0;
      r_ts_fine   <= '0;
      r_ts_sat    <= 1'b0;
    end else if (w_capture) begin
      r_ts_coarse <= r_c2;
      r_ts_fine   <= w_fine;
      r_ts_sat    <= w_sat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dead <= '0;
    end else if (w_accept) begin
      r_dead <= DCW'(DEAD_CYCLES - 1);
    end else if ((r_state == DEAD) && (r_dead != '0)) begin
      r_dead <= r_dead - 1'b1;
    end
  end

  // Any armed hit outside IDLE is lost, including one coinciding with the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_missed <= '0;
    end else if (w_hit && enable && (r_state != IDLE) && (r_missed != 8'hFF)) begin
      r_missed <= r_missed + 8'd1;
    end
  end

  assign ts_valid    = (r_state == HOLD);
  assign busy        = (r_state != IDLE);
  assign ts_coarse   = r_ts_coarse;
  assign ts_fine     = r_ts_fine;
  assign ts_sat      = r_ts_sat;
  assign coarse_wrap = r_wrap;
  assign missed_cnt  = r_missed;

endmodule

// File: doc/tdc_tap_encoder.md
Name: tdc_tap_encoder

Overview:
- Downstream stage of the TDC tapped delay line; consumes its NTAPS-wide thermometer tap vector.
- Samples the tap vector every clock and detects a hit.
- Converts the thermometer code to a binary fine time and pairs it with a free-running coarse count.
- Presents one timestamp per hit on a valid/ready handshake, followed by a dead-time window.

Parameters:
- NTAPS, 32, number of delay-line taps consumed.
- FINE_W, 6, fine-time width; must satisfy 2^FINE_W > NTAPS.
- COARSE_W, 16, coarse counter width.
- DEAD_CYCLES, 4, clock cycles of dead time after each accepted timestamp; must be >= 1.

Ports:
- clk, input, 1, system clock; all flops on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- enable, input, 1, arms hit detection.
- taps_in, input, NTAPS, raw delay-line tap outputs; asynchronous to clk.
- ts_valid, output, 1, timestamp available.
- ts_ready, input, 1, consumer accepts timestamp.
- ts_coarse, output, COARSE_W, coarse count of the sampling edge.
- ts_fine, output, FINE_W, number of taps traversed (0..NTAPS).
- ts_sat, output, 1, all taps were high at sampling (edge outran the line).
- coarse_wrap, output, 1, one-cycle pulse when the coarse counter rolls over to 0.
- missed_cnt, output, 8, saturating count of dropped hits.
- busy, output, 1, FSM not in IDLE.

Behaviour:
- Reset (rst_n low, async): every flop cleared. All outputs are 0.
- Sampling:
  - s1 <= taps_in every cycle.
  - s2 <= s1.
  - c1 <= coarse_cnt in parallel with s1; c2 <= c1, so coarse travels aligned with the taps.
- Coarse counter:
  - Increments every cycle and wraps from 2^COARSE_W-1 to 0.
  - coarse_wrap is high in the cycle coarse_cnt == 0 after a rollover; not asserted on the first cycle after reset.
- Hit detect:
  - hit = s2[0] & ~s2q0, where s2q0 is s2[0] registered.
  - Only a rising edge counts; a held-high line is not re-detected.
- Encode:
  - fine = popcount of the (optionally filtered) s2 vector, computed in the same cycle as detect.
  - ts_sat = (s2 all ones).
- FSM states: IDLE, HOLD, DEAD.
  - IDLE: if hit & enable, register fine/c2/sat into the output regs and go to HOLD.
    - Output regs hold the filtered popcount, c2 and sat taken in the hit cycle.
    - Latency: taps sampled at edge E; ts_valid high after edge E+2.
  - HOLD: ts_valid = 1; outputs stable. On ts_valid & ts_ready, go to DEAD and load the dead counter with DEAD_CYCLES-1.
  - DEAD: the counter decrements each cycle; at 0, go to IDLE.
  - Dead time is exactly DEAD_CYCLES cycles, with the first IDLE cycle following them.
- Dropped hits:
  - A hit while enable = 1 in HOLD or DEAD increments missed_cnt, saturating at 255.
  - A hit with enable = 0 is ignored, not counted.
  - missed_cnt clears only on reset.
- enable deasserted in HOLD: the pending timestamp is kept until accepted, then DEAD and IDLE proceed normally.
- A hit and a handshake in the same cycle: the handshake completes and the hit is counted as missed.
- ts_coarse, ts_fine and ts_sat change only on entry to HOLD.

Optional Feature:
- Macro: TDC_BUBBLE_FILTER_EN.
- Defined:
  - Before popcount, each bit i is replaced by majority(s2[i-1], s2[i], s2[i+1]).
  - Virtual boundaries are s2[-1] = 1 and s2[NTAPS] = 0.
  - This removes single-tap bubbles.
- Undefined: raw popcount of s2; no extra logic.
- Latency is identical in both builds.

Test Plan:
- Reset, then taps_in = 0x00000000 → 0x000000FF, ts_ready = 1 → ts_valid for 1 cycle two edges after sampling, with ts_fine = 8, ts_sat = 0, and ts_coarse = counter value at the sampling edge.
- Bubble taps 0x000000FB → ts_fine = 8 with TDC_BUBBLE_FILTER_EN defined; ts_fine = 7 without it.
- taps_in = 0xFFFFFFFF on the first high sample → ts_fine = 32, ts_sat = 1.
- ts_ready held low for 10 cycles while 3 more rising edges arrive → ts_valid and outputs stay stable, and missed_cnt = 3. Then raise ts_ready → DEAD for 4 cycles, then IDLE; a hit 2 cycles after the handshake increments missed_cnt to 4.
- enable = 0 with 5 hits → no ts_valid and missed_cnt unchanged. Assert rst_n low while in HOLD → ts_valid, busy and missed_cnt go to 0 immediately.
- With COARSE_W = 4, run 20 cycles → a coarse_wrap pulse at the cycle count == 0 after 15; a hit sampled at count 15 reports ts_coarse = 15.
